// File: rtl/vote_tally.sv
// vote_tally: one-vote-per-ballot tally machine with saturating per-candidate
// counters, a timed voter acknowledge and a registered result display port.
// Optional feature macro: BALLOT_TIMEOUT_EN (auto-closes an unanswered ballot
// after TIMEOUT_CYCLES cycles in OPEN; absent by default).
module vote_tally #(
    parameter int NUM_CAND       = 4,
    parameter int SEL_W          = 2,
    parameter int CNT_W          = 8,
    parameter int ACK_CYCLES     = 100000000,
    parameter int TIMEOUT_CYCLES = 1000000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic                arm,
    input  logic [NUM_CAND-1:0] valid_vote,
    input  logic [SEL_W-1:0]    sel,
    output logic                ballot_open,
    output logic                vote_ack,
    output logic                reject,
    output logic [CNT_W-1:0]    count_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_ACK    = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    // Counter loaded with ACK_CYCLES-1 on accept and run down to zero.
    localparam int                ACK_W    = (ACK_CYCLES > 2) ? $clog2(ACK_CYCLES) : 1;
    localparam logic [ACK_W-1:0]  ACK_LOAD = ACK_W'(ACK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam bit                CFG_OK   = ((2 ** SEL_W) >= NUM_CAND) &&
                                             (ACK_CYCLES > 0) && (TIMEOUT_CYCLES > 0);

    // Reject configurations the selector or counters cannot represent.
    if (!CFG_OK) begin : g_cfg_bad
        $error("vote_tally: illegal parameter combination");
    end

    // True when exactly one candidate bit is set.
    function automatic logic is_one_hot(input logic [NUM_CAND-1:0] v);
        return (v != {NUM_CAND{1'b0}}) &&
               ((v & (v - NUM_CAND'(1))) == {NUM_CAND{1'b0}});
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   tally_r [NUM_CAND];
    logic [CNT_W-1:0]   tally_sel_s;
    logic [ACK_W-1:0]   ack_cnt_r;
    logic [ACK_W-1:0]   ack_cnt_s;
    logic               accept_s;
    logic               reject_s;
    logic               any_vote_s;
    logic               tmo_expire_s;
    logic               ballot_open_r;
    logic               vote_ack_r;
    logic               reject_r;
    logic [CNT_W-1:0]   count_out_r;

    assign any_vote_s  = |valid_vote;
    assign ballot_open = ballot_open_r;
    assign vote_ack    = vote_ack_r;
    assign reject      = reject_r;
    assign count_out   = count_out_r;

`ifdef BALLOT_TIMEOUT_EN
    localparam int               TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_r;

    // Count edges spent in OPEN; cleared whenever the ballot is not open so
    // each new ballot starts from zero on its arming edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r == ST_OPEN) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end
    end

    assign tmo_expire_s = (state_r == ST_OPEN) && (tmo_cnt_r == TMO_LAST);
`else
    assign tmo_expire_s = 1'b0;
`endif

    // Pick tally[sel]; out-of-range selectors read as zero.
    always_comb begin
        tally_sel_s = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_CAND; i++) begin
            if (sel == SEL_W'(i)) begin
                tally_sel_s = tally_r[i];
            end else begin
                tally_sel_s = tally_sel_s;
            end
        end
    end

    // Next-state, accept and reject decisions; mode=1 overrides every state.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        reject_s  = 1'b0;
        ack_cnt_s = ack_cnt_r;
        if (mode) begin
            state_s  = ST_RESULT;
            reject_s = any_vote_s;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A vote arriving with arm is still rejected.
                    reject_s = any_vote_s;
                    if (arm) begin
                        state_s = ST_OPEN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_OPEN: begin
                    // An accept on the expiry edge takes priority.
                    if (is_one_hot(valid_vote)) begin
                        accept_s  = 1'b1;
                        state_s   = ST_ACK;
                        ack_cnt_s = ACK_LOAD;
                    end else if (tmo_expire_s) begin
                        state_s  = ST_IDLE;
                        reject_s = 1'b1;
                    end else begin
                        state_s  = ST_OPEN;
                        reject_s = any_vote_s;
                    end
                end
                ST_ACK: begin
                    reject_s = any_vote_s;
                    if (ack_cnt_r == {ACK_W{1'b0}}) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s   = ST_ACK;
                        ack_cnt_s = ack_cnt_r - ACK_W'(1);
                    end
                end
                ST_RESULT: begin
                    reject_s = any_vote_s;
                    state_s  = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, acknowledge counter and registered outputs derived from next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            ack_cnt_r     <= {ACK_W{1'b0}};
            ballot_open_r <= 1'b0;
            vote_ack_r    <= 1'b0;
            reject_r      <= 1'b0;
            count_out_r   <= {CNT_W{1'b0}};
        end else begin
            state_r       <= state_s;
            ack_cnt_r     <= ack_cnt_s;
            ballot_open_r <= (state_s == ST_OPEN);
            vote_ack_r    <= (state_s == ST_ACK);
            reject_r      <= reject_s;
            count_out_r   <= mode ? tally_sel_s : {CNT_W{1'b0}};
        end
    end

    // Saturating tallies; they move only on an accepted one-hot vote.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                tally_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if (accept_s && valid_vote[i] && (tally_r[i] != CNT_MAX)) begin
                    tally_r[i] <= tally_r[i] + CNT_W'(1);
                end else begin
                    tally_r[i] <= tally_r[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_vote_tally.sv
// Self-checking bench for vote_tally: directed ballot scenarios followed by a
// randomized phase, all compared against an abstract ballot model.
// Timeout scenario is included when BALLOT_TIMEOUT_EN is defined.
module tb_vote_tally;

    localparam int NUM_CAND       = 4;
    localparam int SEL_W          = 2;
    localparam int CNT_W          = 8;
    localparam int ACK_CYCLES     = 4;
    localparam int TIMEOUT_CYCLES = 10;
    localparam int CNT_MAX        = 255;

    logic                clock = 1'b0;
    logic                reset;
    logic                mode;
    logic                arm;
    logic [NUM_CAND-1:0] valid_vote;
    logic [SEL_W-1:0]    sel;
    logic                ballot_open;
    logic                vote_ack;
    logic                reject;
    logic [CNT_W-1:0]    count_out;

    int checks = 0;
    int errors = 0;

    // Abstract ballot model: vote counts, whether a ballot is armed, how many
    // acknowledge cycles remain, whether the display is showing, ballot age.
    int m_tally [NUM_CAND];
    bit m_armed;
    bit m_result;
    int m_ack_left;
    int m_age;
    bit e_rej;
    int e_count;

    vote_tally #(
        .NUM_CAND      (NUM_CAND),
        .SEL_W         (SEL_W),
        .CNT_W         (CNT_W),
        .ACK_CYCLES    (ACK_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mode       (mode),
        .arm        (arm),
        .valid_vote (valid_vote),
        .sel        (sel),
        .ballot_open(ballot_open),
        .vote_ack   (vote_ack),
        .reject     (reject),
        .count_out  (count_out)
    );

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply the ballot rules to the inputs seen on this rising edge.
    function automatic void model_step();
        int votes;
        votes = $countones(valid_vote);
        e_rej = 1'b0;
        if (reset) begin
            for (int i = 0; i < NUM_CAND; i++) m_tally[i] = 0;
            m_armed    = 1'b0;
            m_result   = 1'b0;
            m_ack_left = 0;
            m_age      = 0;
            e_count    = 0;
        end else if (mode) begin
            e_rej      = (votes > 0);
            m_armed    = 1'b0;
            m_ack_left = 0;
            m_result   = 1'b1;
            e_count    = (int'(sel) < NUM_CAND) ? m_tally[sel] : 0;
        end else begin
            e_count = 0;
            if (m_result) begin
                m_result = 1'b0;
                e_rej    = (votes > 0);
            end else if (m_ack_left > 0) begin
                m_ack_left--;
                e_rej = (votes > 0);
            end else if (m_armed) begin
                if (votes == 1) begin
                    for (int i = 0; i < NUM_CAND; i++)
                        if (valid_vote[i] && m_tally[i] < CNT_MAX) m_tally[i]++;
                    m_armed    = 1'b0;
                    m_ack_left = ACK_CYCLES;
                end else begin
                    e_rej = (votes > 1);
                    m_age++;
`ifdef BALLOT_TIMEOUT_EN
                    if (m_age >= TIMEOUT_CYCLES) begin
                        m_armed = 1'b0;
                        e_rej   = 1'b1;
                    end
`endif
                end
            end else begin
                e_rej = (votes > 0);
                if (arm) begin
                    m_armed = 1'b1;
                    m_age   = 0;
                end
            end
        end
    endfunction

    // One clock: update the model on the edge, compare outputs on the falling edge.
    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_eq("ballot_open", ballot_open, m_armed);
        check_eq("vote_ack", vote_ack, (m_ack_left > 0));
        check_eq("reject", reject, e_rej);
        check_eq("count_out", count_out, e_count);
    endtask

    task automatic apply(input logic a, input logic [3:0] v, input logic m, input logic [1:0] s);
        arm        = a;
        valid_vote = v;
        mode       = m;
        sel        = s;
        tick();
        arm        = 1'b0;
        valid_vote = 4'b0000;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply(1'b0, 4'b0000, 1'b0, 2'd0);
    endtask

    initial begin
        int ack_len;
        int first_rej;
        reset      = 1'b1;
        mode       = 1'b0;
        arm        = 1'b0;
        valid_vote = 4'b0000;
        sel        = 2'd0;
        idle(2);
        reset = 1'b0;
        check_eq("rst_count", count_out, 0);
        check_eq("rst_ack", vote_ack, 0);

        // Single accepted vote for candidate 1.
        apply(1'b1, 4'b0000, 1'b0, 2'd0);
        check_eq("s1_open", ballot_open, 1);
        apply(1'b0, 4'b0010, 1'b0, 2'd0);
        check_eq("s1_open_low", ballot_open, 0);
        ack_len = int'(vote_ack);
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, 4'b0000, 1'b0, 2'd0);
            ack_len += int'(vote_ack);
        end
        check_eq("s1_ack_len", ack_len, ACK_CYCLES);
        apply(1'b0, 4'b0000, 1'b1, 2'd1);
        check_eq("s1_tally1", count_out, 1);
        apply(1'b0, 4'b0000, 1'b0, 2'd1);
        check_eq("s1_count_clear", count_out, 0);

        // Multi-hot vote rejected, then a legal vote for candidate 3.
        apply(1'b1, 4'b0000, 1'b0, 2'd0);
        apply(1'b0, 4'b0110, 1'b0, 2'd0);
        check_eq("s2_reject", reject, 1);
        check_eq("s2_still_open", ballot_open, 1);
        apply(1'b0, 4'b1000, 1'b0, 2'd0);
        idle(4);
        apply(1'b0, 4'b0000, 1'b1, 2'd3);
        check_eq("s2_tally3", count_out, 1);
        apply(1'b0, 4'b0000, 1'b1, 2'd2);
        check_eq("s2_tally2", count_out, 0);
        apply(1'b0, 4'b0000, 1'b0, 2'd0);

        // Votes in IDLE and during ACK are rejected.
        apply(1'b0, 4'b0001, 1'b0, 2'd0);
        check_eq("s3_rej_idle", reject, 1);
        apply(1'b1, 4'b0000, 1'b0, 2'd0);
        apply(1'b0, 4'b0010, 1'b0, 2'd0);
        apply(1'b0, 4'b0001, 1'b0, 2'd0);
        check_eq("s3_rej_ack", reject, 1);
        idle(4);
        apply(1'b0, 4'b0000, 1'b1, 2'd0);
        check_eq("s3_tally0", count_out, 0);
        apply(1'b0, 4'b0000, 1'b0, 2'd0);

        // Saturate candidate 2, then one extra vote.
        for (int n = 0; n < CNT_MAX; n++) begin
            apply(1'b1, 4'b0000, 1'b0, 2'd0);
            apply(1'b0, 4'b0100, 1'b0, 2'd0);
            idle(4);
        end
        apply(1'b1, 4'b0000, 1'b0, 2'd0);
        apply(1'b0, 4'b0100, 1'b0, 2'd0);
        check_eq("sat_ack", vote_ack, 1);
        idle(4);
        apply(1'b0, 4'b0000, 1'b1, 2'd2);
        check_eq("sat_tally2", count_out, CNT_MAX);
        apply(1'b0, 4'b0000, 1'b0, 2'd0);

        // Abandon an open ballot by switching to result mode.
        apply(1'b1, 4'b0000, 1'b0, 2'd0);
        apply(1'b0, 4'b0000, 1'b1, 2'd3);
        check_eq("abandon_no_rej", reject, 0);
        check_eq("abandon_closed", ballot_open, 0);
        check_eq("abandon_tally3", count_out, 1);
        apply(1'b0, 4'b0000, 1'b0, 2'd0);

        // Reset in the middle of an acknowledge.
        apply(1'b1, 4'b0000, 1'b0, 2'd0);
        apply(1'b0, 4'b0001, 1'b0, 2'd0);
        apply(1'b0, 4'b0000, 1'b0, 2'd0);
        reset = 1'b1;
        apply(1'b0, 4'b0000, 1'b0, 2'd0);
        reset = 1'b0;
        check_eq("rst_mid_ack", vote_ack, 0);
        for (int s = 0; s < NUM_CAND; s++) begin
            apply(1'b0, 4'b0000, 1'b1, 2'(s));
            check_eq("rst_tally", count_out, 0);
        end
        apply(1'b0, 4'b0000, 1'b0, 2'd0);

`ifdef BALLOT_TIMEOUT_EN
        // Unanswered ballot auto-closes with one reject.
        apply(1'b1, 4'b0000, 1'b0, 2'd0);
        first_rej = 0;
        for (int k = 1; k <= TIMEOUT_CYCLES + 2; k++) begin
            apply(1'b0, 4'b0000, 1'b0, 2'd0);
            if (reject && first_rej == 0) first_rej = k;
        end
        check_eq("tmo_delay", first_rej, TIMEOUT_CYCLES);
        check_eq("tmo_closed", ballot_open, 0);
`else
        first_rej = 0;
`endif

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(199) == 0);
            if ($urandom_range(19) == 0) mode = ~mode;
            arm = ($urandom_range(3) == 0);
            case ($urandom_range(3))
                0, 1:    valid_vote = 4'b0000;
                2:       valid_vote = 4'b0001 << $urandom_range(3);
                default: valid_vote = 4'($urandom);
            endcase
            sel = 2'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vote_tally.md
Name: vote_tally

Overview:
- Consumes the one-cycle valid-vote pulses produced by the per-candidate button debouncers.
- Enforces one vote per ballot: an officer arms the ballot, exactly one vote is accepted, then the machine locks.
- Keeps per-candidate saturating tallies and drives a voter-acknowledge LED.
- In result mode it presents the selected candidate's count to the display logic.

Parameters:
- NUM_CAND, 4: number of candidates; one valid_vote bit per candidate.
- SEL_W, 2: width of sel; must satisfy 2^SEL_W >= NUM_CAND.
- CNT_W, 8: width of each tally counter.
- ACK_CYCLES, 100000000: number of cycles vote_ack is held high (1 s at 100 MHz).
- TIMEOUT_CYCLES, 1000000000: ballot auto-close limit; used only with BALLOT_TIMEOUT_EN.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = voting, 1 = result display.
- arm  input  1  officer ballot-enable; level-sampled each cycle.
- valid_vote  input  NUM_CAND  one-cycle pulses from the debouncers; bit i = candidate i.
- sel  input  SEL_W  candidate index displayed in result mode.
- ballot_open  output  1  high while a ballot is armed and awaiting a vote.
- vote_ack  output  1  high for exactly ACK_CYCLES cycles after an accepted vote.
- reject  output  1  one-cycle pulse on any ignored or illegal vote attempt.
- count_out  output  CNT_W  tally[sel] in result mode, else 0.

Behaviour:
- Reset: synchronous, active-high. All tallies = 0, state = IDLE, ack/timeout counters = 0, all outputs 0. Reset dominates every other input on the same edge.
- All outputs are registered.
- State machine states: IDLE, OPEN, ACK, RESULT.
- Mode priority: mode=1 sampled in any state moves the machine to RESULT on that edge.
  - An open ballot is abandoned with no count change and no reject.
  - An in-progress ACK is cut short and vote_ack drops.
- IDLE:
  - arm=1 -> OPEN.
  - valid_vote != 0 -> reject pulse; stay IDLE.
  - If arm and a vote arrive together, the machine goes to OPEN, the vote is rejected, and no count changes.
- OPEN:
  - ballot_open=1.
  - valid_vote exactly one-hot, bit i -> tally[i] increments, saturating at 2^CNT_W-1 (no wrap) -> ACK.
  - valid_vote with more than one bit set -> reject pulse; stay OPEN; no count change.
  - valid_vote = 0 -> stay OPEN.
  - arm is ignored.
- ACK:
  - vote_ack=1 starting the cycle after the accepting edge, for exactly ACK_CYCLES cycles.
  - Then -> IDLE with vote_ack=0.
  - Any valid_vote during ACK -> reject pulse, no count change.
  - arm is ignored.
- RESULT:
  - count_out = tally[sel], registered, one-cycle latency from sel.
  - sel >= NUM_CAND -> count_out = 0.
  - valid_vote -> reject pulse.
  - mode=0 -> IDLE, and count_out returns to 0 on the next edge.
- Timing of ballot_open: high the cycle after the arming edge; low the cycle after the accepting edge.
- The reject pulse appears the cycle after the offending input edge. Back-to-back offending inputs give back-to-back reject pulses.
- Tallies change only on an accept or on reset.

Optional Feature:
- Macro: BALLOT_TIMEOUT_EN.
- Defined:
  - A counter runs while the machine is in OPEN.
  - If no vote is accepted within TIMEOUT_CYCLES cycles of entering OPEN, the machine goes to IDLE and pulses reject once. No count changes.
  - An accept on the same edge as expiry wins.
- Undefined: OPEN waits indefinitely; no timeout counter is synthesized.

Test Plan (ACK_CYCLES=4, TIMEOUT_CYCLES=10 in bench):
- Reset, then arm=1 for 1 cycle, then valid_vote=4'b0010 for 1 cycle.
  - Required: tally[1]=1; vote_ack high exactly 4 cycles starting the cycle after the vote; ballot_open low after the vote.
  - Then mode=1, sel=1 -> count_out=1 one cycle later.
- Arm, then valid_vote=4'b0110.
  - Required: reject pulse, all tallies unchanged, ballot_open stays 1.
  - Then valid_vote=4'b1000 -> tally[3]=1.
- valid_vote=4'b0001 in IDLE, then again during ACK.
  - Required: two reject pulses; tally[0] unchanged.
- Preload tally[2] to 255 via 255 arm/vote cycles, then one more arm/vote on candidate 2.
  - Required: tally[2] stays 255; vote_ack still asserted.
- Arm, then mode=1 before any vote; sel=3.
  - Required: RESULT entered, no reject, count_out=tally[3].
  - Assert reset mid-ACK -> vote_ack=0 and all tallies=0 on the next cycle.
- With BALLOT_TIMEOUT_EN: arm and send no vote.
  - Required: reject pulse 10 cycles after entering OPEN, ballot_open=0, tallies unchanged.
